// File: rtl/hci_prio_scheduler_pkg.sv
// hci_prio_scheduler_pkg: shared types and constants for the priority scheduler
package hci_prio_scheduler_pkg;
  typedef enum logic [1:0] {
    HCI_SCHED_FIXED_CORE,
    HCI_SCHED_FIXED_HWPE,
    HCI_SCHED_WRR,
    HCI_SCHED_RSVD
  } hci_sched_mode_t;
  typedef enum logic {HCI_PHASE_CORE, HCI_PHASE_HWPE} hci_sched_phase_t;
  localparam int unsigned HCI_SCHED_DEFAULT_QUOTA = 1;
  typedef struct packed {
    logic [1:0] arb_policy;
    logic       invert_prio;
    logic       hwpe_prio;
    logic [7:0] low_prio_max_stall;
  } hci_interconnect_ctrl_t;
endpackage

// File: rtl/hci_prio_scheduler_if.sv
// hci_prio_scheduler_if: per-channel req/gnt of the core and HWPE sides
interface hci_prio_scheduler_if #(
  parameter int unsigned NB_CHAN = 2
);
  logic [NB_CHAN-1:0] core_req, core_gnt, hwpe_req, hwpe_gnt;
  modport master (output core_req, core_gnt, hwpe_req, hwpe_gnt);
  modport slave (input core_req, core_gnt, hwpe_req, hwpe_gnt);
endinterface

// File: rtl/hci_sched_quota_counter.sv
// hci_sched_quota_counter: beat counter of the current phase and its quota compare
module hci_sched_quota_counter #(
  parameter int unsigned QUOTA_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic               inc_i,
  input  logic [QUOTA_W-1:0] quota_i,
  output logic               quota_reached_o
);
  logic [QUOTA_W-1:0] beat_cnt_d, beat_cnt_q;
  always_comb begin
    beat_cnt_d = (clear_i || load_i) ? '0 : inc_i ? beat_cnt_q + 1'b1 : beat_cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) beat_cnt_q <= '0;
    else beat_cnt_q <= beat_cnt_d;
  end
  assign quota_reached_o = beat_cnt_q >= quota_i - 1'b1;
endmodule

// File: rtl/hci_prio_scheduler.sv
// hci_prio_scheduler: weighted round-robin / fixed memory priority between core and HWPE
module hci_prio_scheduler
  import hci_prio_scheduler_pkg::*;
#(
  parameter int unsigned NB_CHAN = 2,
  parameter int unsigned QUOTA_W = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   cfg_valid_i,
  input  logic [1:0]             cfg_mode_i,
  input  logic [QUOTA_W-1:0]     cfg_quota_core_i,
  input  logic [QUOTA_W-1:0]     cfg_quota_hwpe_i,
  input  logic [7:0]             cfg_max_stall_i,
  hci_prio_scheduler_if.slave    bus,
  output hci_interconnect_ctrl_t ctrl_o,
  output logic                   phase_o,
  output logic [CNT_W-1:0]       switch_cnt_o
);
  localparam logic [QUOTA_W-1:0] DEF_QUOTA = QUOTA_W'(HCI_SCHED_DEFAULT_QUOTA);
  hci_sched_mode_t    mode_d, mode_q;
  hci_sched_phase_t   phase_d, phase_q;
  logic [QUOTA_W-1:0] quota_core_d, quota_core_q, quota_hwpe_d, quota_hwpe_q, quota;
  logic [7:0]         max_stall_d, max_stall_q;
  logic [CNT_W-1:0]   switch_cnt_d, switch_cnt_q;
  logic [NB_CHAN-1:0] fav_req, fav_gnt, oth_req;
  logic               beat, other_pending, quota_reached, wrr, switch_evt;
  always_comb begin
    mode_d        = cfg_valid_i ? hci_sched_mode_t'(cfg_mode_i) : mode_q;
    quota_core_d  = !cfg_valid_i ? quota_core_q : cfg_quota_core_i == '0 ? DEF_QUOTA : cfg_quota_core_i;
    quota_hwpe_d  = !cfg_valid_i ? quota_hwpe_q : cfg_quota_hwpe_i == '0 ? DEF_QUOTA : cfg_quota_hwpe_i;
    max_stall_d   = cfg_valid_i ? cfg_max_stall_i : max_stall_q;
    wrr           = mode_q == HCI_SCHED_WRR;
    fav_req       = phase_q == HCI_PHASE_HWPE ? bus.hwpe_req : bus.core_req;
    fav_gnt       = phase_q == HCI_PHASE_HWPE ? bus.hwpe_gnt : bus.core_gnt;
    oth_req       = phase_q == HCI_PHASE_HWPE ? bus.core_req : bus.hwpe_req;
    quota         = phase_q == HCI_PHASE_HWPE ? quota_hwpe_q : quota_core_q;
    beat          = |(fav_req & fav_gnt);
    other_pending = |oth_req;
    phase_d       = clear_i ? HCI_PHASE_CORE
                  : wrr ? ((beat && quota_reached && other_pending) ? hci_sched_phase_t'(~phase_q) : phase_q)
                  : mode_q == HCI_SCHED_FIXED_HWPE ? HCI_PHASE_HWPE : HCI_PHASE_CORE;
    switch_evt    = !clear_i && phase_d != phase_q;
    switch_cnt_d  = clear_i ? '0 : (switch_evt && !(&switch_cnt_q)) ? switch_cnt_q + 1'b1 : switch_cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q       <= HCI_SCHED_FIXED_CORE;
      quota_core_q <= DEF_QUOTA;
      quota_hwpe_q <= DEF_QUOTA;
      max_stall_q  <= '0;
      phase_q      <= HCI_PHASE_CORE;
      switch_cnt_q <= '0;
    end else begin
      mode_q       <= mode_d;
      quota_core_q <= quota_core_d;
      quota_hwpe_q <= quota_hwpe_d;
      max_stall_q  <= max_stall_d;
      phase_q      <= phase_d;
      switch_cnt_q <= switch_cnt_d;
    end
  end
  hci_sched_quota_counter #(.QUOTA_W(QUOTA_W)) i_quota_cnt (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clear_i        (clear_i),
    .load_i         (!wrr || switch_evt),
    .inc_i          (wrr && beat && !quota_reached),
    .quota_i        (quota),
    .quota_reached_o(quota_reached)
  );
  always_comb begin
    ctrl_o                    = '0;
    ctrl_o.hwpe_prio          = phase_q;
    ctrl_o.low_prio_max_stall = max_stall_q;
  end
  assign phase_o      = phase_q;
  assign switch_cnt_o = switch_cnt_q;
endmodule

// File: tb/tb_hci_prio_scheduler.sv
// tb_hci_prio_scheduler: directed self-checking bench for hci_prio_scheduler
module tb_hci_prio_scheduler;
  import hci_prio_scheduler_pkg::*;
  logic                   clk_i = 0, rst_i = 0, clear_i = 0, cfg_valid_i = 0;
  logic [1:0]             cfg_mode_i = 0;
  logic [7:0]             cfg_quota_core_i = 0, cfg_quota_hwpe_i = 0, cfg_max_stall_i = 0;
  hci_interconnect_ctrl_t ctrl_o;
  logic                   phase_o;
  logic [15:0]            switch_cnt_o;
  int                     checks = 0, errors = 0;
  hci_prio_scheduler_if #(.NB_CHAN(2)) bus ();
  hci_prio_scheduler dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .cfg_valid_i(cfg_valid_i),
    .cfg_mode_i(cfg_mode_i), .cfg_quota_core_i(cfg_quota_core_i),
    .cfg_quota_hwpe_i(cfg_quota_hwpe_i), .cfg_max_stall_i(cfg_max_stall_i),
    .bus(bus), .ctrl_o(ctrl_o), .phase_o(phase_o), .switch_cnt_o(switch_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic traffic(input logic [1:0] cr, cg, hr, hg);
    bus.core_req = cr;
    bus.core_gnt = cg;
    bus.hwpe_req = hr;
    bus.hwpe_gnt = hg;
  endtask
  task automatic cfg_write(input logic [1:0] m, input logic [7:0] qc, qh, ms, input logic clr);
    cfg_valid_i = 1;
    cfg_mode_i = m;
    cfg_quota_core_i = qc;
    cfg_quota_hwpe_i = qh;
    cfg_max_stall_i = ms;
    clear_i = clr;
    tick();
    cfg_valid_i = 0;
    clear_i = 0;
  endtask
  task automatic pulse_clear();
    clear_i = 1;
    tick();
    clear_i = 0;
  endtask
  task automatic test_reset();
    rst_i = 1;
    for (int i = 0; i < 2; i++) begin
      traffic(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
      tick();
    end
    rst_i = 0;
    tick();
    checks++; if (ctrl_o !== '0) begin errors++; $display("FAIL reset_ctrl got %h want 0", ctrl_o); end
    checks++; if (phase_o !== 1'b0) begin errors++; $display("FAIL reset_phase got %b want 0", phase_o); end
    checks++; if (switch_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_switch_cnt got %0d want 0", switch_cnt_o); end
  endtask
  task automatic check_period5(input string tag);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (phase_o !== ((k % 5) >= 3)) begin
        errors++; $display("FAIL %s_phase k=%0d got %b want %b", tag, k, phase_o, (k % 5) >= 3);
      end
      checks++;
      if (switch_cnt_o !== 16'(2 * (k / 5) + ((k % 5) >= 3))) begin
        errors++; $display("FAIL %s_switch_cnt k=%0d got %0d want %0d", tag, k, switch_cnt_o, 2 * (k / 5) + ((k % 5) >= 3));
      end
      tick();
    end
  endtask
  task automatic test_wrr_period();
    traffic(2'b11, 2'b11, 2'b11, 2'b11);
    cfg_write(2'd2, 8'd3, 8'd2, 8'd0, 1'b0);
    check_period5("wrr");
  endtask
  task automatic test_clear();
    repeat (8) tick();
    checks++; if (phase_o !== 1'b1) begin errors++; $display("FAIL pre_clear_phase got %b want 1", phase_o); end
    checks++; if (switch_cnt_o !== 16'd7) begin errors++; $display("FAIL pre_clear_switch_cnt got %0d want 7", switch_cnt_o); end
    pulse_clear();
    checks++; if (phase_o !== 1'b0) begin errors++; $display("FAIL clear_phase got %b want 0", phase_o); end
    checks++; if (switch_cnt_o !== 16'd0) begin errors++; $display("FAIL clear_switch_cnt got %0d want 0", switch_cnt_o); end
    check_period5("post_clear");
  endtask
  task automatic test_starve();
    traffic(2'b01, 2'b01, 2'b00, 2'b00);
    pulse_clear();
    cfg_write(2'd2, 8'd2, 8'd2, 8'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (phase_o !== 1'b0) begin errors++; $display("FAIL starve_phase cyc=%0d got %b want 0", i, phase_o); end
    end
    bus.hwpe_req = 2'b10;
    tick();
    checks++; if (phase_o !== 1'b1) begin errors++; $display("FAIL starve_switch_phase got %b want 1", phase_o); end
    checks++; if (switch_cnt_o !== 16'd1) begin errors++; $display("FAIL starve_switch_cnt got %0d want 1", switch_cnt_o); end
  endtask
  task automatic test_fixed_hwpe();
    traffic(2'b00, 2'b00, 2'b00, 2'b00);
    pulse_clear();
    cfg_write(2'd2, 8'd3, 8'd2, 8'd0, 1'b0);
    traffic(2'b10, 2'b10, 2'b00, 2'b00);
    tick();
    cfg_write(2'd1, 8'd3, 8'd2, 8'd0, 1'b0);
    checks++; if (phase_o !== 1'b0) begin errors++; $display("FAIL fixed_edge1_phase got %b want 0", phase_o); end
    tick();
    checks++; if (phase_o !== 1'b1) begin errors++; $display("FAIL fixed_edge2_phase got %b want 1", phase_o); end
    for (int i = 0; i < 20; i++) begin
      traffic(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
      tick();
      checks++; if (ctrl_o.hwpe_prio !== 1'b1) begin errors++; $display("FAIL fixed_hold cyc=%0d got %b want 1", i, ctrl_o.hwpe_prio); end
    end
    checks++; if (switch_cnt_o !== 16'd1) begin errors++; $display("FAIL fixed_switch_cnt got %0d want 1", switch_cnt_o); end
  endtask
  task automatic test_zero_quota();
    traffic(2'b11, 2'b11, 2'b11, 2'b11);
    checks++; if (ctrl_o.low_prio_max_stall !== 8'd0) begin errors++; $display("FAIL stall_before got %0d want 0", ctrl_o.low_prio_max_stall); end
    cfg_write(2'd2, 8'd0, 8'd0, 8'd5, 1'b1);
    checks++; if (ctrl_o.low_prio_max_stall !== 8'd5) begin errors++; $display("FAIL stall_after got %0d want 5", ctrl_o.low_prio_max_stall); end
    checks++; if (switch_cnt_o !== 16'd0) begin errors++; $display("FAIL zq_clear_cnt got %0d want 0", switch_cnt_o); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (phase_o !== k[0]) begin errors++; $display("FAIL zq_phase k=%0d got %b want %b", k, phase_o, k[0]); end
      checks++; if (switch_cnt_o !== 16'(k)) begin errors++; $display("FAIL zq_switch_cnt k=%0d got %0d want %0d", k, switch_cnt_o, k); end
      tick();
    end
  endtask
  initial begin
    traffic(2'b00, 2'b00, 2'b00, 2'b00);
    test_reset();
    test_wrr_period();
    test_clear();
    test_starve();
    test_fixed_hwpe();
    test_zero_quota();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
